// File: rtl/pipe_stage_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid_pkg
// Description : Shared core header for the pipeline stage registers. Holds
//               the payload width of each stage boundary, the per-slot
//               operation encoding and the occupancy-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_skid_pkg;

    // Packed stage-bundle widths, one per core stage boundary
    localparam int PIPE_WIDTH_IF_ID = 64;   // pc + instruction
    localparam int PIPE_WIDTH_ID_EX = 148;  // pc + operands + immediate + control
    localparam int PIPE_WIDTH_EX_DM = 106;  // alu result + store data + control
    localparam int PIPE_WIDTH_DM_WB = 71;   // writeback value + rd + control

    // What a slot does with its main (M) and skid (K) entries this cycle
    typedef enum logic [2:0] {
        SLOT_IDLE   = 3'd0,  // nothing moves
        SLOT_LOAD_M = 3'd1,  // M empty, new word lands in M
        SLOT_PASS   = 3'd2,  // M drains and is refilled in the same cycle
        SLOT_LOAD_K = 3'd3,  // M stalled, new word parks in K
        SLOT_K_TO_M = 3'd4,  // M drains, parked word moves up from K
        SLOT_DRAIN  = 3'd5,  // M drains, nothing arrives
        SLOT_FLUSH  = 3'd6   // drop everything held
    } slot_op_e;

    // Bits needed to count up to 2*depth held entries
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_slot
// Description : One 2-entry skid slot (main entry M + skid entry K) with a
//               registered in_ready, synchronous flush and optional payload
//               clearing.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_slot
    import pipe_stage_skid_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             r_m_valid_q;
    logic             r_k_valid_q;
    logic             r_in_ready_q;
    logic [WIDTH-1:0] r_m_data_q;
    logic [WIDTH-1:0] r_k_data_q;

    logic             w_m_valid_d;
    logic             w_k_valid_d;
    logic             w_in_ready_d;
    logic [WIDTH-1:0] w_m_data_d;
    logic [WIDTH-1:0] w_k_data_d;

    logic             w_accept;
    logic             w_drain;
    slot_op_e         w_op;

    // Decide this cycle's slot operation from the two handshakes
    always_comb begin
        w_accept = in_valid & r_in_ready_q;
        w_drain  = r_m_valid_q & out_ready;
        w_op     = SLOT_IDLE;
        if (flush) begin
            w_op = SLOT_FLUSH;
        end else if (r_k_valid_q) begin
            // in_ready is low while K is full, so only a drain can happen
            if (w_drain) begin
                w_op = SLOT_K_TO_M;
            end
        end else if (w_accept) begin
            if (!r_m_valid_q) begin
                w_op = SLOT_LOAD_M;
            end else if (w_drain) begin
                w_op = SLOT_PASS;
            end else begin
                w_op = SLOT_LOAD_K;
            end
        end else if (w_drain) begin
            w_op = SLOT_DRAIN;
        end
    end

    // Next valid bits, payloads and in_ready for the chosen operation
    always_comb begin
        w_m_valid_d = r_m_valid_q;
        w_k_valid_d = r_k_valid_q;
        w_m_data_d  = r_m_data_q;
        w_k_data_d  = r_k_data_q;
        case (w_op)
            SLOT_LOAD_M, SLOT_PASS: begin
                w_m_valid_d = 1'b1;
                w_m_data_d  = in_data;
            end
            SLOT_LOAD_K: begin
                w_k_valid_d = 1'b1;
                w_k_data_d  = in_data;
            end
            SLOT_K_TO_M: begin
                w_m_valid_d = 1'b1;
                w_k_valid_d = 1'b0;
                w_m_data_d  = r_k_data_q;
            end
            SLOT_DRAIN: begin
                w_m_valid_d = 1'b0;
            end
            SLOT_FLUSH: begin
                w_m_valid_d = 1'b0;
                w_k_valid_d = 1'b0;
                if (CLEAR_DATA) begin
                    w_m_data_d = '0;
                    w_k_data_d = '0;
                end
            end
            default: begin
            end
        endcase
        // Registered ready: accept next cycle only if K will be free
        w_in_ready_d = ~w_k_valid_d;
    end

    // Control flops; in_ready stays low until the first edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid_q  <= 1'b0;
            r_k_valid_q  <= 1'b0;
            r_in_ready_q <= 1'b0;
        end else begin
            r_m_valid_q  <= w_m_valid_d;
            r_k_valid_q  <= w_k_valid_d;
            r_in_ready_q <= w_in_ready_d;
        end
    end

    generate
        if (CLEAR_DATA) begin : g_clear_data
            // Payload flops cleared on reset
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_m_data_q <= '0;
                    r_k_data_q <= '0;
                end else begin
                    r_m_data_q <= w_m_data_d;
                    r_k_data_q <= w_k_data_d;
                end
            end
        end else begin : g_keep_data
            // Payload flops without reset; stale contents are harmless behind valid
            always_ff @(posedge clk) begin
                r_m_data_q <= w_m_data_d;
                r_k_data_q <= w_k_data_d;
            end
        end
    endgenerate

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_m_valid_q;
    assign out_data  = r_m_data_q;
    assign occupancy = {1'b0, r_m_valid_q} + {1'b0, r_k_valid_q};

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Generic pipeline stage register. DEPTH chained 2-entry skid
//               slots carrying a WIDTH-bit payload with valid/ready, a
//               synchronous flush and a summed occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

    localparam int c_occ_w = occ_width(DEPTH);

    // Handshake chain: index s is the input of slot s, index DEPTH the stage output
    logic [DEPTH:0]   w_valid;
    logic [DEPTH:0]   w_ready;
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic [1:0]       w_slot_occ [DEPTH];
    logic [c_occ_w-1:0] w_occ_sum;

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = in_data;
    assign in_ready       = w_ready[0];
    assign w_ready[DEPTH] = out_ready;
    assign out_valid      = w_valid[DEPTH];
    assign out_data       = w_data[DEPTH];

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_slot
            pipe_skid_slot #(
                .WIDTH      (WIDTH),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .in_valid   (w_valid[s]),
                .in_ready   (w_ready[s]),
                .in_data    (w_data[s]),
                .out_valid  (w_valid[s+1]),
                .out_ready  (w_ready[s+1]),
                .out_data   (w_data[s+1]),
                .occupancy  (w_slot_occ[s])
            );
        end
    endgenerate

    // Total entries held: sum of every slot's valid bits (never exceeds 2*DEPTH)
    always_comb begin
        w_occ_sum = '0;
        for (int s = 0; s < DEPTH; s++) begin
            w_occ_sum = w_occ_sum + c_occ_w'(w_slot_occ[s]);
        end
    end

    assign occupancy = w_occ_sum;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. Four instances
//               (DEPTH 1/2/3, both payload-clear modes); one is selected at
//               a time, the others sit idle and drained.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic [1:0]  sel;

    logic [3:0]  v_in_ready;
    logic [3:0]  v_out_valid;
    logic [15:0] v_out_data [4];
    logic [1:0]  occ0;
    logic [2:0]  occ1;
    logic [2:0]  occ2;
    logic [1:0]  occ3;

    logic        o_in_ready;
    logic        o_out_valid;
    logic [15:0] o_out_data;
    logic [3:0]  o_occ;

    int          n_tests;
    int          n_fail;
    logic [15:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: DEPTH 1, payload cleared
    pipe_stage_skid #(.WIDTH(16), .DEPTH(1), .CLEAR_DATA(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush && sel == 2'd0),
        .in_valid(in_valid && sel == 2'd0), .in_ready(v_in_ready[0]), .in_data(in_data),
        .out_valid(v_out_valid[0]), .out_ready(sel == 2'd0 ? out_ready : 1'b1),
        .out_data(v_out_data[0]), .occupancy(occ0));

    // DUT 1: DEPTH 2, payload cleared
    pipe_stage_skid #(.WIDTH(16), .DEPTH(2), .CLEAR_DATA(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush && sel == 2'd1),
        .in_valid(in_valid && sel == 2'd1), .in_ready(v_in_ready[1]), .in_data(in_data),
        .out_valid(v_out_valid[1]), .out_ready(sel == 2'd1 ? out_ready : 1'b1),
        .out_data(v_out_data[1]), .occupancy(occ1));

    // DUT 2: DEPTH 3, payload kept
    pipe_stage_skid #(.WIDTH(16), .DEPTH(3), .CLEAR_DATA(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush && sel == 2'd2),
        .in_valid(in_valid && sel == 2'd2), .in_ready(v_in_ready[2]), .in_data(in_data),
        .out_valid(v_out_valid[2]), .out_ready(sel == 2'd2 ? out_ready : 1'b1),
        .out_data(v_out_data[2]), .occupancy(occ2));

    // DUT 3: DEPTH 1, payload kept
    pipe_stage_skid #(.WIDTH(16), .DEPTH(1), .CLEAR_DATA(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush && sel == 2'd3),
        .in_valid(in_valid && sel == 2'd3), .in_ready(v_in_ready[3]), .in_data(in_data),
        .out_valid(v_out_valid[3]), .out_ready(sel == 2'd3 ? out_ready : 1'b1),
        .out_data(v_out_data[3]), .occupancy(occ3));

    assign o_in_ready  = v_in_ready[sel];
    assign o_out_valid = v_out_valid[sel];
    assign o_out_data  = v_out_data[sel];

    // Occupancy of the selected instance, zero-extended
    always_comb begin
        o_occ = 4'd0;
        case (sel)
            2'd0:    o_occ = {2'b00, occ0};
            2'd1:    o_occ = {1'b0, occ1};
            2'd2:    o_occ = {1'b0, occ2};
            default: o_occ = {2'b00, occ3};
        endcase
    end

    // Scoreboard: log transfers of the coming edge, then advance one cycle
    task automatic cycle();
        logic        take_in;
        logic        take_out;
        logic [15:0] exp_data;
        take_in  = in_valid && o_in_ready;
        take_out = o_out_valid && out_ready;
        if (take_out) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_spurious: got out_data %h, required no output (queue empty)", o_out_data);
            end else begin
                exp_data = sb.pop_front();
                if (o_out_data !== exp_data) begin
                    n_fail++;
                    $display("FAIL sb_order: got %h required %h", o_out_data, exp_data);
                end
            end
        end
        if (flush) sb.delete();
        else if (take_in) sb.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic select_dut(input int k);
        sel       = 2'(k);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel = 2'd0;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", o_out_valid); end
        n_tests++; if (o_occ !== 4'd0) begin n_fail++; $display("FAIL reset_occ: got %0d required 0", o_occ); end
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b required 0", o_in_ready); end
        n_tests++; if (o_out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0000", o_out_data); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b required 1", o_in_ready); end
        // Load two words then hit reset mid-cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0055; cycle();
        in_data = 16'h0066; cycle();
        in_valid = 1'b0;
        n_tests++; if (o_occ !== 4'd2) begin n_fail++; $display("FAIL midrst_preload_occ: got %0d required 2", o_occ); end
        rst = 1'b1;
        #2;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %0b required 0", o_out_valid); end
        n_tests++; if (o_occ !== 4'd0) begin n_fail++; $display("FAIL midrst_occ: got %0d required 0", o_occ); end
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %0b required 0", o_in_ready); end
        n_tests++; if (o_out_data !== 16'h0) begin n_fail++; $display("FAIL midrst_out_data: got %h required 0000", o_out_data); end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_early_ready: got %0b required 0", o_in_ready); end
        @(posedge clk); #1;
        n_tests++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b required 1", o_in_ready); end
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_valid: got %0b required 0", o_out_valid); end
    endtask

    task automatic test_streaming();
        select_dut(1);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 16);
            in_data  = 16'(k + 1);
            if (k < 16) begin
                n_tests++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready k=%0d: got %0b required 1", k, o_in_ready); end
            end
            n_tests++;
            if (o_out_valid !== (k >= 2 && k < 18)) begin
                n_fail++; $display("FAIL stream_out_valid k=%0d: got %0b required %0b", k, o_out_valid, (k >= 2 && k < 18));
            end
            if (k >= 2 && k < 18) begin
                n_tests++; if (o_out_data !== 16'(k - 1)) begin n_fail++; $display("FAIL stream_out_data k=%0d: got %h required %h", k, o_out_data, 16'(k - 1)); end
            end
            cycle();
        end
        in_valid = 1'b0;
        n_tests++; if (o_occ !== 4'd0) begin n_fail++; $display("FAIL stream_end_occ: got %0d required 0", o_occ); end
    endtask

    task automatic test_backpressure();
        logic took;
        select_dut(0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h000A; cycle();
        in_data = 16'h000B; cycle();
        in_data = 16'h000C;
        n_tests++; if (o_occ !== 4'd2) begin n_fail++; $display("FAIL bp_occ: got %0d required 2", o_occ); end
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b required 0", o_in_ready); end
        n_tests++; if (o_out_data !== 16'h000A) begin n_fail++; $display("FAIL bp_head: got %h required 000a", o_out_data); end
        cycle();
        n_tests++; if (o_occ !== 4'd2) begin n_fail++; $display("FAIL bp_hold_occ: got %0d required 2", o_occ); end
        n_tests++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %0b required 0", o_in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            took = in_valid && o_in_ready;
            cycle();
            if (took) in_valid = 1'b0;
        end
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_undelivered: got %0d words left required 0", sb.size()); end
        n_tests++; if (o_occ !== 4'd0) begin n_fail++; $display("FAIL bp_end_occ: got %0d required 0", o_occ); end
    endtask

    task automatic test_flush();
        select_dut(1);
        flush = 1'b1; cycle(); flush = 1'b0;
        n_tests++; if (o_in_ready !== 1'b1 || o_occ !== 4'd0) begin n_fail++; $display("FAIL flush_empty: got ready %0b occ %0d required 1/0", o_in_ready, o_occ); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0011; cycle();
        in_data = 16'h0022; cycle();
        n_tests++; if (o_occ !== 4'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d required 2", o_occ); end
        n_tests++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_hs: got ready %0b valid %0b required 1/1", o_in_ready, o_out_valid); end
        n_tests++; if (o_out_data !== 16'h0011) begin n_fail++; $display("FAIL flush_pre_head: got %h required 0011", o_out_data); end
        // Flush together with an in and an out transfer
        flush = 1'b1; out_ready = 1'b1; in_data = 16'h0033; cycle();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %0b required 0", o_out_valid); end
        n_tests++; if (o_occ !== 4'd0) begin n_fail++; $display("FAIL flush_occ: got %0d required 0", o_occ); end
        n_tests++; if (o_out_data !== 16'h0) begin n_fail++; $display("FAIL flush_clear_data: got %h required 0000", o_out_data); end
        cycle(); cycle();
        n_tests++; if (o_out_valid !== 1'b0 || o_occ !== 4'd0) begin n_fail++; $display("FAIL flush_dropped_in: got valid %0b occ %0d required 0/0", o_out_valid, o_occ); end
    endtask

    task automatic test_clear_data_mode();
        select_dut(3);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0077; cycle();
        in_valid = 1'b0;
        n_tests++; if (o_out_valid !== 1'b1 || o_out_data !== 16'h0077) begin n_fail++; $display("FAIL keep_pre: got valid %0b data %h required 1/0077", o_out_valid, o_out_data); end
        flush = 1'b1; cycle(); flush = 1'b0;
        n_tests++; if (o_out_valid !== 1'b0 || o_occ !== 4'd0) begin n_fail++; $display("FAIL keep_flush_valid: got valid %0b occ %0d required 0/0", o_out_valid, o_occ); end
        n_tests++; if (o_out_data !== 16'h0077) begin n_fail++; $display("FAIL keep_flush_data: got %h required 0077", o_out_data); end
        select_dut(2);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0099; cycle();
        in_valid = 1'b0; cycle(); cycle();
        n_tests++; if (o_out_valid !== 1'b1 || o_out_data !== 16'h0099) begin n_fail++; $display("FAIL keep3_latency: got valid %0b data %h required 1/0099", o_out_valid, o_out_data); end
        flush = 1'b1; cycle(); flush = 1'b0;
        n_tests++; if (o_out_valid !== 1'b0 || o_out_data !== 16'h0099) begin n_fail++; $display("FAIL keep3_flush: got valid %0b data %h required 0/0099", o_out_valid, o_out_data); end
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            select_dut(d);
            for (int c = 0; c < 3400; c++) begin
                in_valid  = ($urandom_range(0, 99) < 60);
                in_data   = 16'($urandom);
                out_ready = ($urandom_range(0, 99) < 65);
                flush     = ($urandom_range(0, 199) == 0);
                n_tests++; if (int'(o_occ) != sb.size()) begin n_fail++; $display("FAIL rand_occ d=%0d c=%0d: got %0d required %0d", d + 1, c, o_occ, sb.size()); end
                n_tests++; if (int'(o_occ) > 2 * (d + 1)) begin n_fail++; $display("FAIL rand_cap d=%0d c=%0d: got %0d required <=%0d", d + 1, c, o_occ, 2 * (d + 1)); end
                if (d == 0) begin
                    n_tests++; if (o_in_ready !== (sb.size() < 2)) begin n_fail++; $display("FAIL rand_ready c=%0d: got %0b required %0b", c, o_in_ready, (sb.size() < 2)); end
                    n_tests++; if (o_out_valid !== (sb.size() > 0)) begin n_fail++; $display("FAIL rand_valid c=%0d: got %0b required %0b", c, o_out_valid, (sb.size() > 0)); end
                end
                cycle();
            end
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            repeat (3 * d + 8) cycle();
            n_tests++; if (sb.size() != 0 || o_occ !== 4'd0) begin n_fail++; $display("FAIL rand_drain d=%0d: got %0d left occ %0d required 0/0", d + 1, sb.size(), o_occ); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 16'h0; sel = 2'd0; n_tests = 0; n_fail = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_clear_data_mode();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
